// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the MM:SS stopwatch: FSM state encoding,
// BCD digit limits, divider counter sizing and BCD pair increment.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    ADJUST = 2'd2
  } state_t;

  localparam logic [3:0] TENS_MAX  = 4'd5;
  localparam logic [3:0] UNITS_MAX = 4'd9;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_pair_t;

  // Counter width able to hold 0..period-1, never narrower than one bit.
  function automatic int cnt_width(input int unsigned period);
    return (period <= 1) ? 1 : $clog2(period);
  endfunction

  // 00..59 increment with wrap; the >= compares keep an illegal value from sticking.
  function automatic bcd_pair_t bcd_inc(input bcd_pair_t v);
    bcd_pair_t r;
    r = v;
    if (v.units >= UNITS_MAX) begin
      r.units = 4'd0;
      r.tens  = (v.tens >= TENS_MAX) ? 4'd0 : v.tens + 4'd1;
    end else begin
      r.units = v.units + 4'd1;
    end
    return r;
  endfunction

  function automatic logic bcd_is_max(input bcd_pair_t v);
    return (v.tens == TENS_MAX) && (v.units == UNITS_MAX);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running clock divider producing a one-cycle tick every CLK_HZ/TICK_HZ
// enabled cycles; holds its count while disabled and restarts on clr.
module tick_divider
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PERIOD = (TICK_HZ == 0 || CLK_HZ < TICK_HZ) ? 1 : CLK_HZ / TICK_HZ;
  localparam int          W      = cnt_width(PERIOD);
  localparam logic [W-1:0] LAST  = W'(PERIOD - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // NOTE: sequential state uses <= so every register samples pre-edge values,
  // independent of the order statements or blocks are evaluated in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/mmss_time_keeper.sv
// Stopwatch core: run/pause/adjust FSM, MM:SS BCD counters and the adjust
// blink mask, all registered, fed from three tick dividers.
module mmss_time_keeper
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned COUNT_HZ = 1,
  parameter int unsigned ADJ_HZ   = 2,
  parameter int unsigned BLINK_HZ = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pause,
  input  logic       sel,
  input  logic       adj,
  output logic [3:0] minutes_tens,
  output logic [3:0] minutes_units,
  output logic [3:0] seconds_tens,
  output logic [3:0] seconds_units,
  output logic       running,
  output logic [3:0] blink_mask
);

  state_t    state, state_nxt;
  bcd_pair_t mins, secs;
  logic      pause_q, pause_rise, enter_adjust;
  logic      blink_phase, blink_phase_nxt;
  logic      count_tick, adj_tick, blink_tick;

  tick_divider #(.CLK_HZ(CLK_HZ), .TICK_HZ(COUNT_HZ)) u_count_div (
    .clk(clk), .reset(reset), .en(state == RUN), .clr(enter_adjust), .tick(count_tick)
  );

  tick_divider #(.CLK_HZ(CLK_HZ), .TICK_HZ(ADJ_HZ)) u_adj_div (
    .clk(clk), .reset(reset), .en(state == ADJUST), .clr(enter_adjust), .tick(adj_tick)
  );

  tick_divider #(.CLK_HZ(CLK_HZ), .TICK_HZ(BLINK_HZ)) u_blink_div (
    .clk(clk), .reset(reset), .en(state == ADJUST), .clr(enter_adjust), .tick(blink_tick)
  );

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    pause_rise      = pause & ~pause_q;
    enter_adjust    = adj && (state != ADJUST);
    state_nxt       = state;
    blink_phase_nxt = blink_phase;

    case (state)
      PAUSED, RUN: begin
        if (adj)             state_nxt = ADJUST;
        else if (pause_rise) state_nxt = (state == RUN) ? PAUSED : RUN;
      end
      ADJUST:  if (!adj) state_nxt = PAUSED;
      default: state_nxt = PAUSED;
    endcase

    if (state_nxt != ADJUST || enter_adjust) blink_phase_nxt = 1'b0;
    else if (blink_tick)                     blink_phase_nxt = ~blink_phase;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= PAUSED;
      pause_q     <= 1'b1;  // a button held through reset must not read as a press
      mins        <= '0;
      secs        <= '0;
      running     <= 1'b0;
      blink_phase <= 1'b0;
      blink_mask  <= 4'b0000;
    end else begin
      state       <= state_nxt;
      pause_q     <= pause;
      running     <= (state_nxt == RUN);
      blink_phase <= blink_phase_nxt;

      if (state_nxt == ADJUST && blink_phase_nxt) blink_mask <= sel ? 4'b0011 : 4'b1100;
      else                                        blink_mask <= 4'b0000;

      case (state)
        RUN: begin
          if (count_tick) begin
            secs <= bcd_inc(secs);
            if (bcd_is_max(secs)) mins <= bcd_inc(mins);
          end
        end
        ADJUST: begin
          if (adj_tick) begin
            if (sel) secs <= bcd_inc(secs);
            else     mins <= bcd_inc(mins);
          end
        end
        default: ;
      endcase
    end
  end

  assign minutes_tens  = mins.tens;
  assign minutes_units = mins.units;
  assign seconds_tens  = secs.tens;
  assign seconds_units = secs.units;

endmodule

// File: tb/tb_mmss_time_keeper.sv
// Directed bench for mmss_time_keeper at CLK_HZ=8: count, carry/wrap, pause
// fraction retention, adjust with blink, priority and async reset behaviour.
module tb_mmss_time_keeper;

  logic       clk = 1'b0;
  logic       reset, pause, sel, adj;
  logic [3:0] minutes_tens, minutes_units, seconds_tens, seconds_units;
  logic       running;
  logic [3:0] blink_mask;
  logic [15:0] digits;

  int tests = 0;
  int fails = 0;

  assign digits = {minutes_tens, minutes_units, seconds_tens, seconds_units};

  mmss_time_keeper #(.CLK_HZ(8), .COUNT_HZ(1), .ADJ_HZ(2), .BLINK_HZ(4)) dut (
    .clk(clk), .reset(reset), .pause(pause), .sel(sel), .adj(adj),
    .minutes_tens(minutes_tens), .minutes_units(minutes_units),
    .seconds_tens(seconds_tens), .seconds_units(seconds_units),
    .running(running), .blink_mask(blink_mask)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; pause = 1'b0; sel = 1'b0; adj = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  task automatic pulse_pause();
    pause = 1'b1;
    step(1);
    pause = 1'b0;
  endtask

  // From 00:00 in PAUSED, reach mm:ss through ADJUST (4 cycles per increment).
  task automatic preload(input int mm, input int ss);
    sel = 1'b0; adj = 1'b1;
    step(1 + 4 * mm);
    sel = 1'b1;
    step(4 * ss);
    adj = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    reset = 1'b1; pause = 1'b0; sel = 1'b0; adj = 1'b0;
    #1;
    tests++; if (digits !== 16'h0000) begin fails++; $display("FAIL reset_digits: got %h want 0000", digits); end
    tests++; if (running !== 1'b0) begin fails++; $display("FAIL reset_running: got %b want 0", running); end
    tests++; if (blink_mask !== 4'b0000) begin fails++; $display("FAIL reset_mask: got %b want 0000", blink_mask); end
    step(2);
    reset = 1'b0;
    step(3);
    tests++; if ({running, digits} !== 17'h0_0000) begin fails++; $display("FAIL reset_idle: got run=%b %h want run=0 0000", running, digits); end
  endtask

  task automatic test_run();
    do_reset();
    pulse_pause();
    tests++; if (running !== 1'b1) begin fails++; $display("FAIL run_running: got %b want 1", running); end
    step(7);
    tests++; if (digits !== 16'h0000) begin fails++; $display("FAIL run_7: got %h want 0000", digits); end
    step(1);
    tests++; if (digits !== 16'h0001) begin fails++; $display("FAIL run_8: got %h want 0001", digits); end
    step(8);
    tests++; if (digits !== 16'h0002) begin fails++; $display("FAIL run_16: got %h want 0002", digits); end
    step(64);
    tests++; if (digits !== 16'h0010) begin fails++; $display("FAIL run_80: got %h want 0010", digits); end
  endtask

  task automatic test_carry();
    do_reset();
    preload(0, 59);
    tests++; if (digits !== 16'h0059) begin fails++; $display("FAIL preload_0059: got %h want 0059", digits); end
    pulse_pause();
    step(7);
    tests++; if (digits !== 16'h0059) begin fails++; $display("FAIL carry_before: got %h want 0059", digits); end
    step(1);
    tests++; if (digits !== 16'h0100) begin fails++; $display("FAIL carry_min: got %h want 0100", digits); end
    do_reset();
    preload(59, 59);
    tests++; if (digits !== 16'h5959) begin fails++; $display("FAIL preload_5959: got %h want 5959", digits); end
    pulse_pause();
    step(8);
    tests++; if (digits !== 16'h0000) begin fails++; $display("FAIL wrap_5959: got %h want 0000", digits); end
  endtask

  task automatic test_pause_hold();
    do_reset();
    pulse_pause();
    step(19);
    pulse_pause();
    tests++; if ({running, digits} !== 17'h0_0002) begin fails++; $display("FAIL pause_enter: got run=%b %h want run=0 0002", running, digits); end
    step(100);
    tests++; if (digits !== 16'h0002) begin fails++; $display("FAIL pause_hold: got %h want 0002", digits); end
    pulse_pause();
    step(3);
    tests++; if ({running, digits} !== 17'h1_0002) begin fails++; $display("FAIL resume_3: got run=%b %h want run=1 0002", running, digits); end
    step(1);
    tests++; if (digits !== 16'h0003) begin fails++; $display("FAIL resume_4: got %h want 0003", digits); end
  endtask

  task automatic test_adjust();
    do_reset();
    preload(0, 58);
    tests++; if (digits !== 16'h0058) begin fails++; $display("FAIL preload_0058: got %h want 0058", digits); end
    sel = 1'b1; adj = 1'b1;
    step(1);
    tests++; if ({running, blink_mask} !== 5'b0_0000) begin fails++; $display("FAIL adj_a0: got run=%b mask=%b want 0 0000", running, blink_mask); end
    step(1);
    tests++; if (blink_mask !== 4'b0000) begin fails++; $display("FAIL adj_a1_mask: got %b want 0000", blink_mask); end
    step(1);
    tests++; if (blink_mask !== 4'b0011) begin fails++; $display("FAIL adj_a2_mask: got %b want 0011", blink_mask); end
    step(1);
    tests++; if ({blink_mask, digits} !== 20'h3_0058) begin fails++; $display("FAIL adj_a3: got mask=%b %h want 0011 0058", blink_mask, digits); end
    step(1);
    tests++; if ({blink_mask, digits} !== 20'h0_0059) begin fails++; $display("FAIL adj_a4: got mask=%b %h want 0000 0059", blink_mask, digits); end
    step(4);
    tests++; if ({blink_mask, digits} !== 20'h0_0000) begin fails++; $display("FAIL adj_a8: got mask=%b %h want 0000 0000", blink_mask, digits); end
    step(3);
    tests++; if ({blink_mask, digits} !== 20'h3_0000) begin fails++; $display("FAIL adj_a11: got mask=%b %h want 0011 0000", blink_mask, digits); end
    sel = 1'b0;
    step(3);
    tests++; if ({blink_mask, digits} !== 20'hC_0100) begin fails++; $display("FAIL adj_sel_move: got mask=%b %h want 1100 0100", blink_mask, digits); end
    adj = 1'b0;
    step(1);
    tests++; if ({running, blink_mask, digits} !== 21'h0_0_0100) begin fails++; $display("FAIL adj_exit: got run=%b mask=%b %h want 0 0000 0100", running, blink_mask, digits); end
  endtask

  task automatic test_priority();
    do_reset();
    sel = 1'b1;
    pulse_pause();
    step(3);
    pause = 1'b1; adj = 1'b1;
    step(1);
    tests++; if ({running, blink_mask} !== 5'b0_0000) begin fails++; $display("FAIL prio_enter: got run=%b mask=%b want 0 0000", running, blink_mask); end
    pause = 1'b0; step(1);
    pause = 1'b1; step(1);
    pause = 1'b0; step(1);
    tests++; if ({running, blink_mask} !== 5'b0_0011) begin fails++; $display("FAIL prio_ignore_pause: got run=%b mask=%b want 0 0011", running, blink_mask); end
    adj = 1'b0;
    step(1);
    tests++; if ({running, blink_mask} !== 5'b0_0000) begin fails++; $display("FAIL prio_exit: got run=%b mask=%b want 0 0000", running, blink_mask); end
  endtask

  task automatic test_async_reset();
    do_reset();
    pulse_pause();
    step(20);
    tests++; if ({running, digits} !== 17'h1_0002) begin fails++; $display("FAIL ar_before: got run=%b %h want run=1 0002", running, digits); end
    #2;
    reset = 1'b1; pause = 1'b1;
    #1;
    tests++; if ({running, blink_mask, digits} !== 21'h0_0_0000) begin fails++; $display("FAIL ar_immediate: got run=%b mask=%b %h want all 0", running, blink_mask, digits); end
    step(2);
    reset = 1'b0;
    step(5);
    tests++; if (running !== 1'b0) begin fails++; $display("FAIL ar_held_button: got run=%b want 0", running); end
    pause = 1'b0;
    step(1);
    pulse_pause();
    tests++; if (running !== 1'b1) begin fails++; $display("FAIL ar_press_after: got run=%b want 1", running); end
    step(7);
    tests++; if (digits !== 16'h0000) begin fails++; $display("FAIL ar_first_7: got %h want 0000", digits); end
    step(1);
    tests++; if (digits !== 16'h0001) begin fails++; $display("FAIL ar_first_8: got %h want 0001", digits); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_carry();
    test_pause_hold();
    test_adjust();
    test_priority();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
